// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - mode codes, state encoding and timer sizing shared by the interrupt blocks
package int_pkg;

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_CHANGE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } gen_state_e;

  function automatic int timer_width(input int pulse_width, input int holdoff_time);
    int longest;
    longest = (pulse_width > holdoff_time) ? pulse_width : holdoff_time;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/int_gen_timer.sv
// rtl/int_gen_timer.sv - shared phase down-counter, terminal count when it reaches zero
module int_gen_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/external_int_generator.sv
// rtl/external_int_generator.sv - queued external interrupt pin driver with pulse/toggle modes
module external_int_generator
  import int_pkg::*;
#(
  parameter logic       PIN_IDLE_STATE       = 1'b1,
  parameter logic [1:0] RISE_SENSE_CONTROL   = MODE_RISE,
  parameter logic [1:0] FALL_SENSE_CONTROL   = MODE_FALL,
  parameter logic [1:0] CHANGE_SENSE_CONTROL = MODE_CHANGE,
  parameter int         PULSE_WIDTH          = 50000,
  parameter int         HOLDOFF_TIME         = 50000,
  parameter int         PENDING_MAX          = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable_generator,
  input  logic [1:0]                          signal_mode,
  input  logic                                event_req,
  input  logic                                clear_overflow,
  output logic                                int_pin,
  output logic                                busy,
  output logic                                event_done,
  output logic [$clog2(PENDING_MAX+1)-1:0]    pending_count,
  output logic                                overflow
);

  localparam int TW = timer_width(PULSE_WIDTH, HOLDOFF_TIME);
  localparam int CW = $clog2(PENDING_MAX + 1);
  // The timer counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [TW-1:0] PW_LOAD   = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] HT_LOAD   = TW'(HOLDOFF_TIME - 1);
  localparam logic [CW-1:0] PEND_FULL = CW'(PENDING_MAX);

  gen_state_e    state_q, state_d;
  logic          pin_q, pin_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [1:0]    mode_q, mode_d;
  logic          tmr_load, tmr_tc;
  logic [TW-1:0] tmr_val;
  logic          launch, accept, drop, mode_known;

  int_gen_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  assign mode_known = (signal_mode == RISE_SENSE_CONTROL) ||
                      (signal_mode == FALL_SENSE_CONTROL) ||
                      (signal_mode == CHANGE_SENSE_CONTROL);

  always_comb begin
    state_d  = state_q;
    pin_d    = pin_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
    mode_d   = mode_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    launch   = 1'b0;
    accept   = 1'b0;
    drop     = 1'b0;
    if (!enable_generator) begin
      state_d  = ST_IDLE;
      pend_d   = '0;
      pin_d    = PIN_IDLE_STATE;
      tmr_load = 1'b1;
    end else begin
      launch = (state_q == ST_IDLE) && ((pend_q != '0) || event_req);
      accept = event_req && (launch || (pend_q != PEND_FULL));
      drop   = event_req && !accept;
      if (accept && !launch) begin
        pend_d = pend_q + 1'b1;
      end else if (launch && !accept) begin
        pend_d = pend_q - 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          // Reserved codes still consume the event but leave the pin alone.
          if (launch) begin
            mode_d = signal_mode;
            if (mode_known) begin
              state_d  = ST_ASSERT;
              tmr_load = 1'b1;
              tmr_val  = PW_LOAD;
              if (signal_mode == RISE_SENSE_CONTROL) begin
                pin_d = 1'b1;
              end else if (signal_mode == FALL_SENSE_CONTROL) begin
                pin_d = 1'b0;
              end else begin
                pin_d = ~pin_q;
              end
            end
          end
        end
        ST_ASSERT: begin
          if (tmr_tc) begin
            done_d   = 1'b1;
            state_d  = ST_HOLDOFF;
            tmr_load = 1'b1;
            tmr_val  = HT_LOAD;
            if (mode_q == RISE_SENSE_CONTROL) begin
              pin_d = 1'b0;
            end else if (mode_q == FALL_SENSE_CONTROL) begin
              pin_d = 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (tmr_tc) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pin_q   <= PIN_IDLE_STATE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      mode_q  <= FALL_SENSE_CONTROL;
    end else begin
      state_q <= state_d;
      pin_q   <= pin_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
    end
  end

  assign int_pin       = pin_q;
  assign busy          = (state_q != ST_IDLE);
  assign event_done    = done_q;
  assign pending_count = pend_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_external_int_generator.sv
// tb/tb_external_int_generator.sv - self-checking bench for external_int_generator
module tb_external_int_generator;
  import int_pkg::*;

  localparam int PW   = 4;
  localparam int HT   = 3;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] sm  = MODE_FALL;
  logic       req = 1'b0;
  logic       clr = 1'b0;
  logic       int_pin, busy, event_done, overflow;
  logic [1:0] pending_count;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int dsnap;
  bit cmp_en   = 1'b0;

  // Timestamp model: a launch at edge L ends its pulse at L+PW and frees the block after L+PW+HT.
  int     n         = 0;
  longint idle_at   = -100;
  longint pulse_end = -100;
  logic   m_pin     = 1'b1;
  logic   m_busy    = 1'b0;
  logic   m_done    = 1'b0;
  logic   m_ovf     = 1'b0;
  int     m_pend    = 0;
  logic [1:0] m_mode = MODE_FALL;
  bit     m_launch, m_drop;

  external_int_generator #(
    .PIN_IDLE_STATE (1'b1),
    .PULSE_WIDTH    (PW),
    .HOLDOFF_TIME   (HT),
    .PENDING_MAX    (PMAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_generator (en),
    .signal_mode      (sm),
    .event_req        (req),
    .clear_overflow   (clr),
    .int_pin          (int_pin),
    .busy             (busy),
    .event_done       (event_done),
    .pending_count    (pending_count),
    .overflow         (overflow)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pin = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_pend = 0;
      m_mode = MODE_FALL; idle_at = -100; pulse_end = -100;
    end else begin
      n++;
      if (!en) begin
        m_pin = 1'b1; m_pend = 0; m_done = 1'b0; idle_at = n; pulse_end = -100;
        if (clr) m_ovf = 1'b0;
      end else begin
        m_launch = (n > idle_at) && (m_pend > 0 || req);
        m_done = (n == pulse_end);
        if (m_done && m_mode != MODE_CHANGE) m_pin = (m_mode == MODE_FALL);
        m_drop = req && !m_launch && (m_pend == PMAX);
        if (req && !m_drop) m_pend++;
        if (m_launch) m_pend--;
        if (m_drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (m_launch) begin
          m_mode = sm;
          if (sm != MODE_RSVD) begin
            m_pin = (sm == MODE_RISE) ? 1'b1 : (sm == MODE_FALL) ? 1'b0 : ~m_pin;
            pulse_end = n + PW;
            idle_at = n + PW + HT;
          end
        end
      end
      m_busy = (idle_at > n);
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("model", {int_pin, busy, event_done, pending_count, overflow},
            {m_pin, m_busy, m_done, m_pend[1:0], m_ovf});
    if (event_done === 1'b1) done_cnt++;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_pin", int_pin, 1);
    check("reset_busy", busy, 0);
    check("reset_pend", pending_count, 0);
    check("reset_ovf", overflow, 0);
    check("reset_done", event_done, 0);

    // FALL single event
    tick(2);
    sm = MODE_FALL; req = 1'b1;
    tick(1); req = 1'b0;
    check("fall_pin_L", int_pin, 0);
    check("fall_busy_L", busy, 1);
    tick(3); check("fall_pin_L3", int_pin, 0);
    tick(1); check("fall_pin_L4", int_pin, 1); check("fall_done_L4", event_done, 1);
    tick(1); check("fall_done_L5", event_done, 0); check("fall_busy_L5", busy, 1);
    tick(1); check("fall_busy_L6", busy, 1);
    tick(1); check("fall_busy_L7", busy, 0);

    // RISE, three back-to-back requests
    tick(2);
    sm = MODE_RISE; req = 1'b1;
    tick(1); check("rise_pin_L", int_pin, 1); check("rise_pend_L", pending_count, 0);
    tick(1); check("rise_pend_L1", pending_count, 1);
    tick(1); check("rise_pend_L2", pending_count, 2);
    req = 1'b0;
    tick(2); check("rise_pin_L4", int_pin, 0);
    tick(4); check("rise_pin_L8", int_pin, 1); check("rise_pend_L8", pending_count, 1);
    tick(8); check("rise_pin_L16", int_pin, 1); check("rise_pend_L16", pending_count, 0);
    check("rise_ovf", overflow, 0);
    tick(8); check("rise_busy_end", busy, 0);

    // Overflow: five requests, one dropped, drop beats a same-cycle clear
    tick(2);
    dsnap = done_cnt;
    sm = MODE_RISE; req = 1'b1;
    tick(1); check("ovf_pend_L", pending_count, 0);
    tick(3); check("ovf_pend_L3", pending_count, 3); check("ovf_flag_L3", overflow, 0);
    clr = 1'b1;
    tick(1); check("ovf_pend_L4", pending_count, 3); check("ovf_drop_wins", overflow, 1);
    req = 1'b0; clr = 1'b0;
    tick(2); check("ovf_sticky", overflow, 1);
    clr = 1'b1;
    tick(1); check("ovf_cleared", overflow, 0);
    clr = 1'b0;
    tick(1); check("ovf_pend_L8", pending_count, 2);
    tick(24); check("ovf_busy_end", busy, 0); check("ovf_pulses", done_cnt - dsnap, 4);

    // Asynchronous reset mid-pulse with a queued event
    tick(2);
    sm = MODE_FALL; req = 1'b1;
    tick(2); req = 1'b0;
    check("arst_pin_pre", int_pin, 0); check("arst_pend_pre", pending_count, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_pin", int_pin, 1); check("arst_busy", busy, 0); check("arst_pend", pending_count, 0);
    tick(1); rst = 1'b0;
    tick(2);

    // CHANGE toggles once per event
    dsnap = done_cnt;
    sm = MODE_CHANGE; req = 1'b1;
    tick(1); check("chg_pin_L", int_pin, 0);
    tick(1); req = 1'b0; check("chg_pend_L1", pending_count, 1);
    tick(3); check("chg_pin_L4", int_pin, 0); check("chg_done_L4", event_done, 1);
    tick(4); check("chg_pin_L8", int_pin, 1);
    tick(4); check("chg_pin_L12", int_pin, 1);
    tick(4); check("chg_busy_end", busy, 0); check("chg_pulses", done_cnt - dsnap, 2);

    // Disable during the second ASSERT cycle
    tick(2);
    dsnap = done_cnt;
    sm = MODE_FALL; req = 1'b1;
    tick(1); check("dis_pin_L", int_pin, 0);
    tick(1); check("dis_pend_L1", pending_count, 1);
    req = 1'b0; en = 1'b0;
    tick(1); check("dis_pin", int_pin, 1); check("dis_pend", pending_count, 0); check("dis_busy", busy, 0);
    req = 1'b1;
    tick(1); check("dis_ignore", pending_count, 0);
    req = 1'b0; en = 1'b1;
    tick(8); check("dis_no_done", done_cnt - dsnap, 0); check("dis_pin_end", int_pin, 1);

    // Mode change mid-pulse is ignored; reserved mode consumes the queued event silently
    dsnap = done_cnt;
    sm = MODE_FALL; req = 1'b1;
    tick(1); tick(1); req = 1'b0; sm = MODE_RSVD;
    check("rsv_pend_L1", pending_count, 1);
    tick(3); check("rsv_pin_L4", int_pin, 1); check("rsv_done_L4", event_done, 1);
    tick(4); check("rsv_pend_L8", pending_count, 0); check("rsv_pin_L8", int_pin, 1); check("rsv_busy_L8", busy, 0);
    req = 1'b1;
    tick(1); req = 1'b0;
    check("rsv_direct_busy", busy, 0); check("rsv_direct_pin", int_pin, 1); check("rsv_direct_pend", pending_count, 0);
    tick(3); check("rsv_pulses", done_cnt - dsnap, 1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/external_int_generator.md
EXTERNAL_INT_GENERATOR -- requirements
Module: external_int_generator

Interface
REQ-001 SHALL have parameter PIN_IDLE_STATE, default 1: int_pin level at reset.
REQ-002 SHALL have parameter RISE_SENSE_CONTROL, default 2'b00: pulse-high mode, idle level 0.
REQ-003 SHALL have parameter FALL_SENSE_CONTROL, default 2'b01: pulse-low mode, idle level 1.
REQ-004 SHALL have parameter CHANGE_SENSE_CONTROL, default 2'b10: toggle mode, one pin toggle per event.
REQ-005 SHALL have parameter PULSE_WIDTH, default 50000: active-phase length in clk cycles, at least 1.
REQ-006 SHALL have parameter HOLDOFF_TIME, default 50000: quiet-phase length after each event in clk cycles, at least 1.
REQ-007 SHALL have parameter PENDING_MAX, default 3: saturation value of the event queue.
REQ-008 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable_generator  input  1  block enable.
- signal_mode  input  2  RISE, FALL or CHANGE code; 2'b11 reserved.
- event_req  input  1  one-cycle request for one pin event.
- clear_overflow  input  1  clears overflow.
- int_pin  output  1  registered external pin drive.
- busy  output  1  high while state is not IDLE.
- event_done  output  1  one-cycle pulse at end of the active phase.
- pending_count  output  $clog2(PENDING_MAX+1)  queued, not-yet-launched events.
- overflow  output  1  sticky flag: an event_req was dropped.

Function
REQ-009 SHALL implement states IDLE, ASSERT and HOLDOFF.
REQ-010 In IDLE, launch SHALL occur when (pending_count>0 or event_req) and enable_generator is high.
REQ-011 pending_count_next SHALL equal pending_count + accepted event_req - launch; simultaneous request and launch nets to zero.
REQ-012 On the launch edge, signal_mode SHALL be latched into an internal mode register, state SHALL go to ASSERT and int_pin SHALL take its active level: 1 for RISE, 0 for FALL, inverted for CHANGE.
REQ-013 Latency SHALL be one edge: an event_req sampled in IDLE with an empty queue drives int_pin on that same edge.
REQ-014 ASSERT SHALL last exactly PULSE_WIDTH cycles; on its final edge:
- int_pin returns to the mode idle level for RISE/FALL; CHANGE keeps the toggled level.
- event_done pulses for one cycle.
- state goes to HOLDOFF.
REQ-015 HOLDOFF SHALL last exactly HOLDOFF_TIME cycles with int_pin unchanged, then go to IDLE; consecutive launches SHALL be at least PULSE_WIDTH+HOLDOFF_TIME+1 cycles apart.
REQ-016 A launch with mode register 2'b11 SHALL consume the event (pending decrements) with no pin activity, no event_done and no state change.
REQ-017 signal_mode changes outside a launch edge SHALL NOT affect an event in progress.
REQ-018 event_req while pending_count==PENDING_MAX with no same-cycle launch SHALL be dropped: the count holds and overflow is set.
REQ-019 overflow SHALL clear on clear_overflow; a drop in the same cycle wins, so overflow stays set.
REQ-020 enable_generator low SHALL, on the next edge:
- force state to IDLE;
- clear pending_count;
- ignore event_req;
- return int_pin to PIN_IDLE_STATE;
- emit no event_done.

Reset
REQ-021 Asserted rst SHALL asynchronously set int_pin=PIN_IDLE_STATE, state=IDLE, pending_count=0, overflow=0, event_done=0, busy=0, timer=0 and mode register=FALL_SENSE_CONTROL.
REQ-022 rst asserted mid-pulse SHALL take effect immediately, without waiting for a clk edge.
REQ-023 Operation SHALL resume on the first clk edge after rst deasserts.

Structure
REQ-024 Mode codes, state encoding and the timer width function SHALL live in a shared package (int_pkg), shared with the interrupt handler.
REQ-025 Timer width SHALL be $clog2(max(PULSE_WIDTH,HOLDOFF_TIME)+1).
REQ-026 One sub-module, int_gen_timer, SHALL provide a single down-counter that is loaded with PULSE_WIDTH or HOLDOFF_TIME and flags terminal count; it is shared by both phases.

Verification (PULSE_WIDTH=4, HOLDOFF_TIME=3, PENDING_MAX=3)
REQ-027 Reset: assert rst mid-cycle -> int_pin=1, busy=0 and pending_count=0 immediately, without a clk edge.
REQ-028 FALL, event_req sampled at edge 10 -> int_pin=0 over edges 10..13 and 1 at edge 14, event_done high after edge 14, busy low from edge 17.
REQ-029 RISE, event_req at edges 10, 11, 12 -> pulses rise at edges 10, 18 and 26; pending_count reads 1, 2, 1, 0 at the expected edges; overflow=0.
REQ-030 Overflow: 5 requests during ASSERT -> pending_count saturates at 3, overflow=1 until clear_overflow, and exactly 4 pulses are emitted in total.
REQ-031 CHANGE from int_pin=1, two requests -> int_pin 1->0 at the first launch and 0->1 eight cycles later; two event_done pulses.
REQ-032 enable_generator low during the second ASSERT cycle -> int_pin=PIN_IDLE_STATE, pending_count=0, no event_done; mode 2'b11 request -> pending consumed, int_pin static.
